// File: rtl/mood_pkg.sv
// Shared types, encodings and constants for the mood regulator front end.
// sat_add is the one saturating update used by the counters and by the FSM lookahead.
package mood_pkg;

    localparam int CNT_W = 6;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic signed [7:0] delta_t;

    typedef enum logic [1:0] {
        PS_ASLEEP = 2'b00,
        PS_AWAKE  = 2'b01,
        PS_DROWSY = 2'b10,
        PS_WAKING = 2'b11
    } phys_state_e;

    localparam logic [2:0] STIM_FEED  = 3'd0;
    localparam logic [2:0] STIM_PLAY  = 3'd1;
    localparam logic [2:0] STIM_PET   = 3'd2;
    localparam logic [2:0] STIM_NOISE = 3'd3;
    localparam logic [2:0] STIM_SCOLD = 3'd4;

    typedef struct packed {
        delta_t energy;
        delta_t stress;
        delta_t pleasure;
    } delta3_t;

    localparam delta3_t DELTA_NONE   = '{energy:  8'sd0, stress:  8'sd0, pleasure:  8'sd0};
    localparam delta3_t DELTA_FEED   = '{energy:  8'sd8, stress:  8'sd0, pleasure:  8'sd0};
    localparam delta3_t DELTA_PLAY   = '{energy: -8'sd4, stress:  8'sd0, pleasure:  8'sd8};
    localparam delta3_t DELTA_PET    = '{energy:  8'sd0, stress: -8'sd4, pleasure:  8'sd4};
    localparam delta3_t DELTA_NOISE  = '{energy:  8'sd0, stress:  8'sd8, pleasure:  8'sd0};
    localparam delta3_t DELTA_SCOLD  = '{energy:  8'sd0, stress:  8'sd4, pleasure: -8'sd8};
    localparam delta3_t TICK_AWAKE   = '{energy: -8'sd1, stress: -8'sd1, pleasure: -8'sd1};
    localparam delta3_t TICK_ASLEEP  = '{energy:  8'sd2, stress: -8'sd2, pleasure:  8'sd0};

    localparam cnt_t ENERGY_RST    = 6'd48;
    localparam cnt_t STRESS_RST    = 6'd0;
    localparam cnt_t PLEASURE_RST  = 6'd32;
    localparam cnt_t DROWSY_THRESH = 6'd16;
    localparam cnt_t CNT_MAX       = 6'd63;

    function automatic delta3_t stim_delta(input logic [2:0] kind);
        delta3_t d;
        d = DELTA_NONE;
        case (kind)
            STIM_FEED:  d = DELTA_FEED;
            STIM_PLAY:  d = DELTA_PLAY;
            STIM_PET:   d = DELTA_PET;
            STIM_NOISE: d = DELTA_NOISE;
            STIM_SCOLD: d = DELTA_SCOLD;
            default:    d = DELTA_NONE;
        endcase
        return d;
    endfunction

    // 9 bits cover 63 + 127 and 0 - 128 without overflow.
    function automatic cnt_t sat_add(input cnt_t cnt, input delta_t delta);
        logic signed [8:0] sum;
        cnt_t              res;
        sum = $signed({3'b000, cnt}) + $signed({delta[7], delta});
        if (sum[8]) begin
            res = '0;
        end else if (sum > $signed({3'b000, CNT_MAX})) begin
            res = CNT_MAX;
        end else begin
            res = sum[CNT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter6.sv
// 6-bit counter that applies a signed 8-bit delta each cycle, clamped to [0,63].
module sat_counter6
    import mood_pkg::*;
#(
    parameter cnt_t RESET_VAL = '0
) (
    input  logic   clk,
    input  logic   reset,
    input  delta_t delta_i,
    output cnt_t   cnt_o
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    always_comb begin
        cnt_d = sat_add(cnt_q, delta_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mood_regulator.sv
// Mood core front end: decay prescaler, stimulus/tick delta merge into three
// saturating counters, and the sleep/wake FSM driving physical_state.
module mood_regulator
    import mood_pkg::*;
#(
    parameter int TICK_DIV     = 1000,
    parameter int DROWSY_TICKS = 8,
    parameter int WAKE_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stim_valid,
    input  logic [2:0] stim_kind,
    output logic       stim_ready,
    output logic [1:0] energy,
    output logic [1:0] stress,
    output logic [1:0] pleasure,
    output logic [1:0] physical_state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DROWSY_TICKS + 1);
    localparam int WW = $clog2(WAKE_CYCLES + 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    phys_state_e   state_q, state_d;
    logic [DW-1:0] drowsy_q, drowsy_d;
    logic [WW-1:0] wake_q, wake_d;

    logic    accept;
    logic    noise_accepted;
    delta3_t stim_d3;
    delta3_t tick_d3;
    delta_t  energy_delta, stress_delta, pleasure_delta;
    cnt_t    energy_cnt, stress_cnt, pleasure_cnt;
    cnt_t    energy_next;

    assign stim_ready     = (state_q != PS_WAKING);
    assign accept         = stim_valid & stim_ready;
    assign noise_accepted = accept && (stim_kind == STIM_NOISE);

    always_comb begin
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Stimulus and tick contributions are merged so a coincident pair lands on one edge.
    always_comb begin
        stim_d3 = DELTA_NONE;
        tick_d3 = DELTA_NONE;
        if (accept && !(state_q == PS_ASLEEP && stim_kind != STIM_NOISE)) begin
            stim_d3 = stim_delta(stim_kind);
        end
        if (tick) begin
            tick_d3 = (state_q == PS_ASLEEP) ? TICK_ASLEEP : TICK_AWAKE;
        end
        energy_delta   = stim_d3.energy   + tick_d3.energy;
        stress_delta   = stim_d3.stress   + tick_d3.stress;
        pleasure_delta = stim_d3.pleasure + tick_d3.pleasure;
        energy_next    = sat_add(energy_cnt, energy_delta);
    end

    sat_counter6 #(.RESET_VAL(ENERGY_RST)) u_energy (
        .clk     (clk),
        .reset   (reset),
        .delta_i (energy_delta),
        .cnt_o   (energy_cnt)
    );

    sat_counter6 #(.RESET_VAL(STRESS_RST)) u_stress (
        .clk     (clk),
        .reset   (reset),
        .delta_i (stress_delta),
        .cnt_o   (stress_cnt)
    );

    sat_counter6 #(.RESET_VAL(PLEASURE_RST)) u_pleasure (
        .clk     (clk),
        .reset   (reset),
        .delta_i (pleasure_delta),
        .cnt_o   (pleasure_cnt)
    );

    // Energy thresholds look at energy_next so the transition agrees with the tick's update.
    always_comb begin
        state_d  = state_q;
        drowsy_d = drowsy_q;
        wake_d   = wake_q;
        case (state_q)
            PS_AWAKE: begin
                if (tick && energy_next < DROWSY_THRESH) begin
                    state_d  = PS_DROWSY;
                    drowsy_d = '0;
                end
            end
            PS_DROWSY: begin
                if (tick) begin
                    if (energy_next >= DROWSY_THRESH) begin
                        state_d  = PS_AWAKE;
                        drowsy_d = '0;
                    end else if (drowsy_q == DW'(DROWSY_TICKS - 1)) begin
                        state_d  = PS_ASLEEP;
                        drowsy_d = '0;
                    end else begin
                        drowsy_d = drowsy_q + 1'b1;
                    end
                end
            end
            PS_ASLEEP: begin
                if (noise_accepted || (tick && energy_next == CNT_MAX)) begin
                    state_d = PS_WAKING;
                    wake_d  = '0;
                end
            end
            PS_WAKING: begin
                if (wake_q == WW'(WAKE_CYCLES - 1)) begin
                    state_d = PS_AWAKE;
                    wake_d  = '0;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            default: state_d = PS_AWAKE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            state_q  <= PS_AWAKE;
            drowsy_q <= '0;
            wake_q   <= '0;
        end else begin
            presc_q  <= presc_d;
            state_q  <= state_d;
            drowsy_q <= drowsy_d;
            wake_q   <= wake_d;
        end
    end

    assign energy         = energy_cnt[5:4];
    assign stress         = stress_cnt[5:4];
    assign pleasure       = pleasure_cnt[5:4];
    assign physical_state = state_q;

endmodule

// File: tb/tb_mood_regulator.sv
// Directed bench for mood_regulator with TICK_DIV=4, DROWSY_TICKS=2, WAKE_CYCLES=16.
// Ticks fall in cycles 3, 7, 11, ... counted from the first cycle after reset.
module tb_mood_regulator;

    logic       clk;
    logic       reset;
    logic       stim_valid;
    logic [2:0] stim_kind;
    logic       stim_ready;
    logic [1:0] energy;
    logic [1:0] stress;
    logic [1:0] pleasure;
    logic [1:0] physical_state;

    int checks;
    int errors;
    int wakeLen;

    mood_regulator #(
        .TICK_DIV     (4),
        .DROWSY_TICKS (2),
        .WAKE_CYCLES  (16)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .stim_valid     (stim_valid),
        .stim_kind      (stim_kind),
        .stim_ready     (stim_ready),
        .energy         (energy),
        .stress         (stress),
        .pleasure       (pleasure),
        .physical_state (physical_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of cycle 0 with reset released.
    task automatic doReset();
        reset      = 1'b1;
        stim_valid = 1'b0;
        stim_kind  = 3'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] kind);
        stim_valid = 1'b1;
        stim_kind  = kind;
        @(posedge clk);
        @(negedge clk);
        stim_valid = 1'b0;
        stim_kind  = 3'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset      = 1'b1;
        stim_valid = 1'b0;
        stim_kind  = 3'd0;
        @(negedge clk);

        // Reset state, then FEED saturation
        doReset();
        checkOutput("rst_energy",   int'(energy), 3);
        checkOutput("rst_stress",   int'(stress), 0);
        checkOutput("rst_pleasure", int'(pleasure), 2);
        checkOutput("rst_phys",     int'(physical_state), 1);
        checkOutput("rst_ready",    int'(stim_ready), 1);
        checkOutput("rst_ecnt",     int'(u_dut.u_energy.cnt_o), 48);
        applyStimulus(3'd0);
        checkOutput("feed1_ecnt", int'(u_dut.u_energy.cnt_o), 56);
        applyStimulus(3'd0);
        checkOutput("feed2_ecnt", int'(u_dut.u_energy.cnt_o), 63);
        applyStimulus(3'd0);
        checkOutput("feed3_ecnt", int'(u_dut.u_energy.cnt_o), 63);
        checkOutput("feed3_level", int'(energy), 3);

        // Decay: 32 ticks by cycle 131, tick 33 ends cycle 131
        doReset();
        waitCycles(131);
        checkOutput("decay_pre_phys", int'(physical_state), 1);
        checkOutput("decay_pre_ecnt", int'(u_dut.u_energy.cnt_o), 16);
        waitCycles(1);
        checkOutput("drowsy_phys",   int'(physical_state), 2);
        checkOutput("drowsy_ecnt",   int'(u_dut.u_energy.cnt_o), 15);
        checkOutput("drowsy_level",  int'(energy), 0);
        checkOutput("drowsy_stress", int'(u_dut.u_stress.cnt_o), 0);
        waitCycles(4);
        checkOutput("drowsy1_phys", int'(physical_state), 2);
        checkOutput("drowsy1_ecnt", int'(u_dut.u_energy.cnt_o), 14);
        waitCycles(4);
        checkOutput("asleep_phys",  int'(physical_state), 0);
        checkOutput("asleep_ecnt",  int'(u_dut.u_energy.cnt_o), 13);
        checkOutput("asleep_scnt",  int'(u_dut.u_stress.cnt_o), 0);
        checkOutput("asleep_pcnt",  int'(u_dut.u_pleasure.cnt_o), 0);

        // Wake: PET ignored while asleep, NOISE wakes
        applyStimulus(3'd2);
        checkOutput("pet_phys", int'(physical_state), 0);
        checkOutput("pet_pcnt", int'(u_dut.u_pleasure.cnt_o), 0);
        checkOutput("pet_scnt", int'(u_dut.u_stress.cnt_o), 0);
        checkOutput("pet_ecnt", int'(u_dut.u_energy.cnt_o), 13);
        applyStimulus(3'd3);
        checkOutput("noise_phys",  int'(physical_state), 3);
        checkOutput("noise_scnt",  int'(u_dut.u_stress.cnt_o), 8);
        checkOutput("noise_ready", int'(stim_ready), 0);
        wakeLen = 0;
        while (stim_ready == 1'b0 && wakeLen < 40) begin
            wakeLen++;
            waitCycles(1);
        end
        checkOutput("waking_len",   wakeLen, 16);
        checkOutput("woke_phys",    int'(physical_state), 1);
        checkOutput("woke_ready",   int'(stim_ready), 1);
        checkOutput("woke_scnt",    int'(u_dut.u_stress.cnt_o), 4);
        checkOutput("woke_ecnt",    int'(u_dut.u_energy.cnt_o), 9);

        // Simultaneous SCOLD and tick; reserved kind in between
        doReset();
        applyStimulus(3'd4);
        applyStimulus(3'd4);
        applyStimulus(3'd4);
        checkOutput("scold3_pcnt", int'(u_dut.u_pleasure.cnt_o), 8);
        checkOutput("scold3_scnt", int'(u_dut.u_stress.cnt_o), 12);
        waitCycles(9);
        applyStimulus(3'd6);
        checkOutput("rsvd_pcnt", int'(u_dut.u_pleasure.cnt_o), 5);
        checkOutput("rsvd_scnt", int'(u_dut.u_stress.cnt_o), 9);
        checkOutput("rsvd_ecnt", int'(u_dut.u_energy.cnt_o), 45);
        waitCycles(2);
        checkOutput("pre_sim_pcnt", int'(u_dut.u_pleasure.cnt_o), 5);
        applyStimulus(3'd4);
        checkOutput("sim_pcnt", int'(u_dut.u_pleasure.cnt_o), 0);
        checkOutput("sim_scnt", int'(u_dut.u_stress.cnt_o), 12);
        checkOutput("sim_ecnt", int'(u_dut.u_energy.cnt_o), 44);
        checkOutput("sim_energy_level", int'(energy), 2);

        // Reset in the fifth WAKING cycle with a FEED offered
        doReset();
        waitCycles(140);
        checkOutput("mw_asleep", int'(physical_state), 0);
        applyStimulus(3'd3);
        waitCycles(4);
        checkOutput("mw_waking", int'(physical_state), 3);
        reset      = 1'b1;
        stim_valid = 1'b1;
        stim_kind  = 3'd0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mw_phys",  int'(physical_state), 1);
        checkOutput("mw_ready", int'(stim_ready), 1);
        checkOutput("mw_ecnt",  int'(u_dut.u_energy.cnt_o), 48);
        checkOutput("mw_scnt",  int'(u_dut.u_stress.cnt_o), 0);
        checkOutput("mw_pcnt",  int'(u_dut.u_pleasure.cnt_o), 32);
        reset      = 1'b0;
        stim_valid = 1'b0;
        waitCycles(3);
        checkOutput("mw_presc_c3", int'(u_dut.u_energy.cnt_o), 48);
        waitCycles(1);
        checkOutput("mw_presc_c4", int'(u_dut.u_energy.cnt_o), 47);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
